regfile_write_arbiter: RTL and testbench

- Owns the single write port (WriteRegister/WriteData/RegWrite) of the 32x32 regfile.
- Shares that port between two requesters, A (core writeback) and B (load/debug unit), using round-robin arbitration with a valid/ready handshake.
- Runs a clear sequence that zeroes registers 1..31 after reset, and again on request, so the regfile never holds X values.
- The regfile's read ports are not touched by this block.

---
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 32x32 regfile: round-robin arbitration
// between requester A (writeback) and B (load/debug), plus a clear sequence
// that zeroes registers 1..31 after reset and on SoftClear.
module regfile_write_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValidA,
    input  logic [4:0]  ReqAddrA,
    input  logic [31:0] ReqDataA,
    output logic        ReqReadyA,
    input  logic        ReqValidB,
    input  logic [4:0]  ReqAddrB,
    input  logic [31:0] ReqDataB,
    output logic        ReqReadyB,
    input  logic        SoftClear,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    output logic        Busy
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    localparam logic [ADDR_W-1:0] CLEAR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(31);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clear_idx;
    logic              r_prio;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic              r_regwrite;

    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_clear_idx_nxt;
    logic              w_prio_nxt;
    logic [ADDR_W-1:0] w_wreg_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_regwrite_nxt;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept_en;
    logic              w_xfer_a;
    logic              w_xfer_b;

    // Round-robin grant; Prio only breaks ties when both requesters are valid
    always_comb begin
        w_grant_a   = ReqValidA && (!ReqValidB || !r_prio);
        w_grant_b   = ReqValidB && (!ReqValidA ||  r_prio);
        w_accept_en = Rst_n && (r_state == ST_RUN) && !SoftClear;
        ReqReadyA   = w_grant_a && w_accept_en;
        ReqReadyB   = w_grant_b && w_accept_en;
        w_xfer_a    = ReqValidA && ReqReadyA;
        w_xfer_b    = ReqValidB && ReqReadyB;
    end

    // Next-state and next-output logic for the CLEAR/RUN machine
    always_comb begin
        w_state_nxt     = r_state;
        w_clear_idx_nxt = r_clear_idx;
        w_prio_nxt      = r_prio;
        w_wreg_nxt      = r_wreg;
        w_wdata_nxt     = r_wdata;
        w_regwrite_nxt  = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                w_wreg_nxt     = r_clear_idx;
                w_wdata_nxt    = '0;
                w_regwrite_nxt = 1'b1;
                if (r_clear_idx == CLEAR_LAST) begin
                    w_clear_idx_nxt = CLEAR_FIRST;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_clear_idx_nxt = r_clear_idx + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (SoftClear) begin
                    w_state_nxt     = ST_CLEAR;
                    w_clear_idx_nxt = CLEAR_FIRST;
                end else if (w_xfer_a) begin
                    w_wreg_nxt     = ReqAddrA;
                    w_wdata_nxt    = ReqDataA;
                    w_regwrite_nxt = (ReqAddrA != '0);
                    w_prio_nxt     = 1'b1;
                end else if (w_xfer_b) begin
                    w_wreg_nxt     = ReqAddrB;
                    w_wdata_nxt    = ReqDataB;
                    w_regwrite_nxt = (ReqAddrB != '0);
                    w_prio_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_RESET;
            r_clear_idx <= CLEAR_FIRST;
            r_prio      <= 1'b0;
            r_wreg      <= '0;
            r_wdata     <= '0;
            r_regwrite  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_idx <= w_clear_idx_nxt;
            r_prio      <= w_prio_nxt;
            r_wreg      <= w_wreg_nxt;
            r_wdata     <= w_wdata_nxt;
            r_regwrite  <= w_regwrite_nxt;
        end
    end

    assign WriteRegister = r_wreg;
    assign WriteData     = r_wdata;
    assign RegWrite      = r_regwrite;
    assign Busy          = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model + regfile model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ReqValidA = 1'b0;
    logic [4:0]  ReqAddrA = '0;
    logic [31:0] ReqDataA = '0;
    logic        ReqReadyA;
    logic        ReqValidB = 1'b0;
    logic [4:0]  ReqAddrB = '0;
    logic [31:0] ReqDataB = '0;
    logic        ReqReadyB;
    logic        SoftClear = 1'b0;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        Busy;

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValidA(ReqValidA), .ReqAddrA(ReqAddrA), .ReqDataA(ReqDataA), .ReqReadyA(ReqReadyA),
        .ReqValidB(ReqValidB), .ReqAddrB(ReqAddrB), .ReqDataB(ReqDataB), .ReqReadyB(ReqReadyB),
        .SoftClear(SoftClear),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Regfile model fed by the DUT write port (r0 hardwired to zero)
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
    always @(posedge Clk) if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;

    // Behavioural model: clear is "writes remaining", arbitration remembers last winner
    logic [5:0]  m_clear_left;
    logic        m_last_was_a;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        exp_ra, exp_rb;

    always_comb begin
        exp_ra = 1'b0;
        exp_rb = 1'b0;
        if (Rst_n && m_clear_left == 6'd0 && !SoftClear) begin
            if (ReqValidA && ReqValidB) begin
                exp_ra = !m_last_was_a;
                exp_rb =  m_last_was_a;
            end else begin
                exp_ra = ReqValidA;
                exp_rb = ReqValidB;
            end
        end
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_clear_left <= 6'd31;
            m_last_was_a <= 1'b0;
            m_rw <= 1'b0;
            m_wr <= '0;
            m_wd <= '0;
        end else if (m_clear_left != 6'd0) begin
            m_rw <= 1'b1;
            m_wr <= 5'(6'd32 - m_clear_left);
            m_wd <= '0;
            m_clear_left <= m_clear_left - 6'd1;
        end else if (SoftClear) begin
            m_rw <= 1'b0;
            m_clear_left <= 6'd31;
        end else if (exp_ra) begin
            m_rw <= (ReqAddrA != 5'd0);
            m_wr <= ReqAddrA;
            m_wd <= ReqDataA;
            m_last_was_a <= 1'b1;
        end else if (exp_rb) begin
            m_rw <= (ReqAddrB != 5'd0);
            m_wr <= ReqAddrB;
            m_wd <= ReqDataB;
            m_last_was_a <= 1'b0;
        end else begin
            m_rw <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge Clk) begin
        chk("regwrite", 32'(RegWrite), 32'(m_rw));
        chk("busy", 32'(Busy), 32'(m_clear_left != 6'd0));
        chk("ready_a", 32'(ReqReadyA), 32'(exp_ra));
        chk("ready_b", 32'(ReqReadyB), 32'(exp_rb));
        chk("write_reg", 32'(WriteRegister), 32'(m_wr));
        chk("write_data", WriteData, m_wd);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_clear_done(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (!Busy) break;
        end
        chk(name, 32'(Busy), 32'd0);
    endtask

    logic acc_a, acc_b;
    logic all_zero;

    initial begin
        // Reset with A asserting a request: nothing may be accepted
        ReqValidA = 1'b1; ReqAddrA = 5'd7; ReqDataA = 32'h1234;
        #3;
        chk("rst_busy", 32'(Busy), 32'd1);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_ready_a", 32'(ReqReadyA), 32'd0);
        ReqValidA = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        step();
        chk("clear_first_reg", 32'(WriteRegister), 32'd1);
        wait_clear_done("clear_done_reset");
        chk("clear_last_reg", 32'(WriteRegister), 32'd31);
        step();
        all_zero = 1'b1;
        for (int i = 1; i < 32; i++) if (rf[i] !== 32'd0) all_zero = 1'b0;
        chk("clear_all_zero", 32'(all_zero), 32'd1);

        // A only: r2 <= 15
        ReqValidA = 1'b1; ReqAddrA = 5'd2; ReqDataA = 32'd15;
        @(negedge Clk);
        chk("a_only_ready", 32'(ReqReadyA), 32'd1);
        step();
        ReqValidA = 1'b0;
        @(negedge Clk);
        chk("a_only_wreg", 32'(WriteRegister), 32'd2);
        chk("a_only_wdata", WriteData, 32'd15);
        step();
        chk("a_only_readback", rf[2], 32'd15);

        // Both valid every cycle: alternating grants, no idle
        ReqValidA = 1'b1; ReqAddrA = 5'd3; ReqDataA = 32'hAAAA;
        ReqValidB = 1'b1; ReqAddrB = 5'd4; ReqDataB = 32'hBBBB;
        repeat (8) step();
        ReqValidA = 1'b0; ReqValidB = 1'b0;
        step();
        chk("both_r3", rf[3], 32'hAAAA);
        chk("both_r4", rf[4], 32'hBBBB);

        // B to register 0: handshake completes, no write
        ReqValidB = 1'b1; ReqAddrB = 5'd0; ReqDataB = 32'd42;
        @(negedge Clk);
        chk("b_r0_ready", 32'(ReqReadyB), 32'd1);
        step();
        ReqValidB = 1'b0;
        @(negedge Clk);
        chk("b_r0_regwrite", 32'(RegWrite), 32'd0);

        // SoftClear with A pending
        step();
        ReqValidA = 1'b1; ReqAddrA = 5'd5; ReqDataA = 32'd77;
        SoftClear = 1'b1;
        @(negedge Clk);
        chk("soft_ready_a", 32'(ReqReadyA), 32'd0);
        step();
        SoftClear = 1'b0;
        wait_clear_done("clear_done_soft");
        chk("soft_accept_first_idle", 32'(ReqReadyA), 32'd1);
        step();
        ReqValidA = 1'b0;
        @(negedge Clk);
        chk("soft_a_wreg", 32'(WriteRegister), 32'd5);
        step();
        chk("soft_r2_cleared", rf[2], 32'd0);
        chk("soft_r5", rf[5], 32'd77);

        // Randomized traffic with hold-until-ready requesters
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            acc_a = ReqValidA && ReqReadyA;
            acc_b = ReqValidB && ReqReadyB;
            step();
            if (!ReqValidA || acc_a) begin
                ReqValidA = ($urandom_range(0, 2) != 0);
                ReqAddrA  = 5'($urandom_range(0, 31));
                ReqDataA  = $urandom;
            end
            if (!ReqValidB || acc_b) begin
                ReqValidB = ($urandom_range(0, 2) != 0);
                ReqAddrB  = 5'($urandom_range(0, 31));
                ReqDataB  = $urandom;
            end
            SoftClear = ($urandom_range(0, 59) == 0);
        end
        SoftClear = 1'b0; ReqValidA = 1'b0; ReqValidB = 1'b0;
        wait_clear_done("clear_done_random");

        // Reset in the middle of a clear: restart from register 1
        step();
        SoftClear = 1'b1;
        step();
        SoftClear = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (RegWrite && WriteRegister == 5'd10) break;
            step();
        end
        chk("midclear_reached_10", 32'(WriteRegister), 32'd10);
        #1 Rst_n = 1'b0;
        #1;
        chk("midclear_rst_regwrite", 32'(RegWrite), 32'd0);
        chk("midclear_rst_wreg", 32'(WriteRegister), 32'd0);
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        step();
        chk("midclear_restart_reg", 32'(WriteRegister), 32'd1);
        chk("midclear_restart_rw", 32'(RegWrite), 32'd1);
        wait_clear_done("clear_done_restart");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
